// File: rtl/mem_word_sequencer_pkg.sv
// Shared definitions for the word-to-byte memory sequencer: operation codes,
// FSM state encoding, beat count and big-endian byte lane helpers.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_ILL   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Bytes per 32-bit word; one memory beat per byte.
    localparam int BEATS = 4;

    // Byte k of a word, big-endian: k=0 is bits 31:24.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // Replace byte k of a word (big-endian lane numbering).
    function automatic logic [31:0] word_put_byte(input logic [31:0] w, input logic [1:0] k,
                                                  input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_word_sequencer_if.sv
// Request/response bundle between a word requester and the byte sequencer.
interface mem_word_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Requester side
    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_byte_ram.sv
// Byte-wide single-port RAM with registered (one-cycle) read, read-first on
// a same-address write. Depth is 2^ADDR_W bytes.
module mem_byte_ram #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem_reg [DEPTH];

    // Write the addressed byte when enabled; always register the old contents out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        rdata <= mem_reg[addr];
    end
endmodule

// File: rtl/mem_word_sequencer.sv
// Turns one 32-bit load/store/swap request into four big-endian byte beats on
// a synchronous-read byte memory. Reads are pipelined one cycle behind the
// address they were issued on; a capture-valid flag tracks that lag so the
// last read capture of a swap can overlap its first write beat.
module mem_word_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_word_sequencer_if.slave  req_bus,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
);
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_e            state_reg;
    op_e               op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [1:0]        cnt_reg;       // beat currently on the memory bus
    logic              cap_vld_reg;   // mem_rdata holds a byte to capture this cycle
    logic              ready_reg;
    logic              rsp_valid_reg;
    logic [31:0]       rsp_rdata_reg;
    logic              rsp_err_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_we_reg;
    logic [7:0]        mem_wdata_reg;

    logic [1:0]        cnt_next;
    logic [1:0]        cap_idx;
    logic              accept;

    assign cnt_next = cnt_reg + 2'd1;
    // The byte arriving now was addressed on the previous beat.
    assign cap_idx  = cnt_reg - 2'd1;
    assign accept   = req_bus.req_valid && ready_reg;

    assign req_bus.req_ready = ready_reg;
    assign req_bus.rsp_valid = rsp_valid_reg;
    assign req_bus.rsp_rdata = rsp_rdata_reg;
    assign req_bus.rsp_err   = rsp_err_reg;
    assign mem_addr          = mem_addr_reg;
    assign mem_we            = mem_we_reg;
    assign mem_wdata         = mem_wdata_reg;

    // Sequencer FSM with registered handshake, response and memory outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_LOAD;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cnt_reg       <= '0;
            cap_vld_reg   <= 1'b0;
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            mem_addr_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_wdata_reg <= '0;
        end else begin
            if (cap_vld_reg) begin
                rsp_rdata_reg <= word_put_byte(rsp_rdata_reg, cap_idx, mem_rdata);
            end

            case (state_reg)
                ST_IDLE: begin
                    ready_reg  <= 1'b1;
                    mem_we_reg <= 1'b0;
                    if (accept) begin
                        ready_reg     <= 1'b0;
                        op_reg        <= op_e'(req_bus.req_op);
                        addr_reg      <= req_bus.req_addr;
                        wdata_reg     <= req_bus.req_wdata;
                        rsp_rdata_reg <= '0;
                        cnt_reg       <= '0;
                        cap_vld_reg   <= 1'b0;
                        case (op_e'(req_bus.req_op))
                            OP_LOAD, OP_SWAP: begin
                                state_reg    <= ST_RD;
                                mem_addr_reg <= req_bus.req_addr;
                            end
                            OP_STORE: begin
                                state_reg     <= ST_WR;
                                mem_addr_reg  <= req_bus.req_addr;
                                mem_we_reg    <= 1'b1;
                                mem_wdata_reg <= word_byte(req_bus.req_wdata, 2'd0);
                            end
                            default: begin
                                state_reg     <= ST_RESP;
                                rsp_valid_reg <= 1'b1;
                                rsp_err_reg   <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_RD: begin
                    if (cap_vld_reg && cnt_reg == 2'd0) begin
                        // Load drain cycle: last byte captured above, word complete.
                        state_reg     <= ST_RESP;
                        rsp_valid_reg <= 1'b1;
                        cap_vld_reg   <= 1'b0;
                    end else if (cnt_reg == LAST_BEAT) begin
                        cap_vld_reg <= 1'b1;
                        cnt_reg     <= '0;
                        if (op_reg == OP_SWAP) begin
                            // First write beat overlaps the final read capture.
                            state_reg     <= ST_WR;
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= addr_reg;
                            mem_wdata_reg <= word_byte(wdata_reg, 2'd0);
                        end
                    end else begin
                        cnt_reg      <= cnt_next;
                        cap_vld_reg  <= 1'b1;
                        mem_addr_reg <= addr_reg + ADDR_W'(cnt_next);
                    end
                end

                ST_WR: begin
                    cap_vld_reg <= 1'b0;
                    if (cnt_reg == LAST_BEAT) begin
                        state_reg     <= ST_RESP;
                        mem_we_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        cnt_reg       <= '0;
                    end else begin
                        cnt_reg       <= cnt_next;
                        mem_addr_reg  <= addr_reg + ADDR_W'(cnt_next);
                        mem_wdata_reg <= word_byte(wdata_reg, cnt_next);
                    end
                end

                default: begin
                    state_reg     <= ST_IDLE;
                    rsp_valid_reg <= 1'b0;
                    rsp_err_reg   <= 1'b0;
                    ready_reg     <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_word_sequencer.sv
// Bench for mem_word_sequencer: the sequencer drives a mem_byte_ram, a byte-
// array model predicts every request's bus schedule and response, and a
// negedge process compares the DUT against that per-cycle expectation.
module tb_mem_word_sequencer;
    import mem_seq_pkg::*;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;
    localparam int TBL    = 4096;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    always #5 clk = ~clk;

    mem_word_sequencer_if #(.ADDR_W(ADDR_W)) sif ();

    mem_word_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_bus   (sif.slave),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    mem_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    typedef struct {
        logic              ready;
        logic              we;
        logic              addr_chk;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
        logic              rv;
        logic              rdata_chk;
        logic [31:0]       rdata;
        logic              err;
    } exp_t;

    exp_t       tbl [TBL];
    logic [7:0] model_ram [DEPTH];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         chk_en = 1'b0;

    function automatic exp_t idle_entry();
        exp_t e;
        e.ready = 1'b1; e.we = 1'b0; e.addr_chk = 1'b0; e.addr = '0; e.wdata = '0;
        e.rv = 1'b0; e.rdata_chk = 1'b0; e.rdata = '0; e.err = 1'b0;
        return e;
    endfunction

    function automatic int ix(input int c);
        return c % TBL;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Edge counter: after edge n settles, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the scheduled expectation, then retire the slot.
    always @(negedge clk) begin
        int i;
        if (chk_en) begin
            i = ix(cyc);
            check("req_ready", 32'(sif.req_ready), 32'(tbl[i].ready));
            check("mem_we",    32'(mem_we),        32'(tbl[i].we));
            check("rsp_valid", 32'(sif.rsp_valid), 32'(tbl[i].rv));
            check("rsp_err",   32'(sif.rsp_err),   32'(tbl[i].err));
            if (tbl[i].addr_chk) check("mem_addr", 32'(mem_addr), 32'(tbl[i].addr));
            if (tbl[i].we) check("mem_wdata", 32'(mem_wdata), 32'(tbl[i].wdata));
            if (tbl[i].rdata_chk) check("rsp_rdata", sif.rsp_rdata, tbl[i].rdata);
            tbl[i] = idle_entry();
        end
    end

    // Issue one request, schedule its expected bus/response trace, wait for the response.
    task automatic do_req(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wd, output logic [31:0] got, output logic got_err);
        int                e0;
        int                lat;
        bit                seen;
        logic [31:0]       old;
        logic [ADDR_W-1:0] ak;
        got = '0;
        got_err = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (sif.req_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL ready_timeout cyc=%0d actual=0 expected=1", cyc);
            return;
        end
        sif.req_valid = 1'b1;
        sif.req_op    = op;
        sif.req_addr  = addr;
        sif.req_wdata = wd;
        @(posedge clk);
        #1;
        e0 = cyc;
        sif.req_valid = 1'b0;
        sif.req_op    = 2'($urandom);
        sif.req_addr  = ADDR_W'($urandom);
        sif.req_wdata = $urandom;

        old = '0;
        for (int k = 0; k < 4; k++) begin
            ak = addr + ADDR_W'(k);
            old = (old << 8) | 32'(model_ram[ak]);
        end
        case (op)
            OP_LOAD:  lat = 5;
            OP_STORE: lat = 4;
            OP_SWAP:  lat = 8;
            default:  lat = 0;
        endcase
        for (int k = 0; k <= lat; k++) tbl[ix(e0 + k)].ready = 1'b0;
        tbl[ix(e0)].rdata_chk = 1'b1;
        tbl[ix(e0)].rdata = '0;
        for (int k = 0; k < 4; k++) begin
            ak = addr + ADDR_W'(k);
            if (op == OP_LOAD || op == OP_SWAP) begin
                tbl[ix(e0 + k)].addr_chk = 1'b1;
                tbl[ix(e0 + k)].addr = ak;
            end
            if (op == OP_STORE || op == OP_SWAP) begin
                int w;
                w = (op == OP_SWAP) ? e0 + 4 + k : e0 + k;
                tbl[ix(w)].we = 1'b1;
                tbl[ix(w)].addr_chk = 1'b1;
                tbl[ix(w)].addr = ak;
                tbl[ix(w)].wdata = 8'(wd >> (24 - 8 * k));
                model_ram[ak] = 8'(wd >> (24 - 8 * k));
            end
        end
        tbl[ix(e0 + lat)].rv = 1'b1;
        tbl[ix(e0 + lat)].rdata_chk = 1'b1;
        tbl[ix(e0 + lat)].rdata = (op == OP_LOAD || op == OP_SWAP) ? old : 32'h0;
        tbl[ix(e0 + lat)].err = (op == OP_ILL);

        seen = 1'b0;
        for (int n = 0; n < lat + 4 && !seen; n++) begin
            @(negedge clk);
            if (sif.rsp_valid) begin
                seen = 1'b1;
                got = sif.rsp_rdata;
                got_err = sif.rsp_err;
            end
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL rsp_timeout op=%0d addr=%0d actual=0 expected=1", op, addr);
        end
        $display("txn op=%0d addr=%0d wdata=%h rdata=%h err=%0d", op, addr, wd, got, got_err);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic        gerr;
        logic [31:0] wv;
        sif.req_valid = 1'b0;
        sif.req_op    = 2'b00;
        sif.req_addr  = '0;
        sif.req_wdata = '0;
        for (int i = 0; i < TBL; i++) tbl[i] = idle_entry();
        for (int i = 0; i < DEPTH; i++) model_ram[i] = 8'h00;

        // Reset values while held in reset
        #3;
        check("rst_ready",     32'(sif.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(sif.rsp_valid), 32'h0);
        check("rst_rsp_rdata", sif.rsp_rdata,      32'h0);
        check("rst_rsp_err",   32'(sif.rsp_err),   32'h0);
        check("rst_mem_we",    32'(mem_we),        32'h0);
        check("rst_mem_addr",  32'(mem_addr),      32'h0);
        check("rst_mem_wdata", 32'(mem_wdata),     32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 32'(sif.req_ready), 32'h1);
        chk_en = 1'b1;

        // Fill memory with known words
        for (int a = 0; a < DEPTH; a += 4) begin
            wv = (a == 4) ? 32'hDEADBEEF : (a == 28) ? 32'h00000040 : $urandom;
            do_req(OP_STORE, ADDR_W'(a), wv, got, gerr);
        end

        do_req(OP_LOAD, 5'd4, 32'h0, got, gerr);
        check("load_deadbeef", got, 32'hDEADBEEF);

        do_req(OP_STORE, 5'd8, 32'h12345678, got, gerr);
        check("store_rdata_zero", got, 32'h0);
        do_req(OP_LOAD, 5'd8, 32'h0, got, gerr);
        check("store_readback", got, 32'h12345678);

        do_req(OP_SWAP, 5'd28, 32'h0000000C, got, gerr);
        check("swap_old", got, 32'h00000040);
        do_req(OP_LOAD, 5'd28, 32'h0, got, gerr);
        check("swap_new", got, 32'h0000000C);

        do_req(OP_STORE, 5'd30, 32'hA1B2C3D4, got, gerr);
        do_req(OP_LOAD, 5'd30, 32'h0, got, gerr);
        check("wrap_load", got, 32'hA1B2C3D4);
        do_req(OP_LOAD, 5'd0, 32'h0, got, gerr);
        check("wrap_low_bytes", {16'h0, got[31:16]}, 32'h0000C3D4);

        do_req(OP_ILL, 5'd3, 32'hFFFFFFFF, got, gerr);
        check("illegal_err", 32'(gerr), 32'h1);
        check("illegal_rdata", got, 32'h0);
        do_req(OP_LOAD, 5'd8, 32'h0, got, gerr);
        check("after_illegal", got, 32'h12345678);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            logic [1:0] rop;
            rop = ($urandom_range(0, 9) == 0) ? OP_ILL : 2'($urandom_range(0, 2));
            do_req(rop, ADDR_W'($urandom), $urandom, got, gerr);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a store to address 0
        @(negedge clk);
        while (!sif.req_ready) @(negedge clk);
        chk_en = 1'b0;
        sif.req_valid = 1'b1;
        sif.req_op    = OP_STORE;
        sif.req_addr  = '0;
        sif.req_wdata = 32'h5A6B7C8D;
        @(posedge clk);
        #1;
        sif.req_valid = 1'b0;
        model_ram[0] = 8'h5A;
        model_ram[1] = 8'h6B;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready",     32'(sif.req_ready), 32'h0);
        check("abort_rsp_valid", 32'(sif.rsp_valid), 32'h0);
        check("abort_rsp_rdata", sif.rsp_rdata,      32'h0);
        check("abort_rsp_err",   32'(sif.rsp_err),   32'h0);
        check("abort_mem_we",    32'(mem_we),        32'h0);
        check("abort_mem_addr",  32'(mem_addr),      32'h0);
        check("abort_mem_wdata", 32'(mem_wdata),     32'h0);
        for (int i = 0; i < TBL; i++) tbl[i] = idle_entry();
        @(negedge clk);
        check("abort_no_rsp", 32'(sif.rsp_valid), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_release", 32'(sif.req_ready), 32'h1);
        chk_en = 1'b1;
        do_req(OP_LOAD, 5'd0, 32'h0, got, gerr);
        check("abort_partial_bytes", {16'h0, got[31:16]}, 32'h00005A6B);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
